// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined IEEE-style multiplier (unpack / multiply / normalise+round), valid/ready.
// Define FP_MUL_FTZ_EN to flush subnormal inputs and results to signed zero.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] p,
  output logic [3:0]           flags,
  output logic [5:0]           cls
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SW    = MAN_W + 1;
  localparam int PW    = 2 * SW;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EMAXF = (1 << EXP_W) - 1;
  localparam int LZW   = $clog2(PW + 1);
  localparam int XW    = EXP_W + LZW + 2;

  localparam logic signed [EXP_W+1:0] BIAS_X = (EXP_W+2)'(BIAS);
  localparam logic [W-1:0] QBIT = {{(W-1){1'b0}}, 1'b1} << (MAN_W - 1);

  localparam logic [5:0] CLS_QNAN = 6'b010000;
  localparam logic [5:0] CLS_SUB  = 6'b001000;
  localparam logic [5:0] CLS_NORM = 6'b000100;
  localparam logic [5:0] CLS_INF  = 6'b000010;
  localparam logic [5:0] CLS_ZERO = 6'b000001;
  localparam logic [3:0] FL_OV  = 4'b1000;
  localparam logic [3:0] FL_UF  = 4'b0100;
  localparam logic [3:0] FL_INV = 4'b0010;
  localparam logic [3:0] FL_IX  = 4'b0001;

  typedef struct packed {
    logic             zero;
    logic             inf;
    logic             nan;
    logic             snan;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
  } op_t;

  function automatic op_t unpack_op(input logic [W-1:0] x);
    op_t              o;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e      = x[W-2:MAN_W];
    f      = x[MAN_W-1:0];
    o.nan  = (&e) & (|f);
    o.snan = o.nan & ~f[MAN_W-1];
    o.inf  = (&e) & ~(|f);
`ifdef FP_MUL_FTZ_EN
    o.zero = ~(|e);
`else
    o.zero = ~(|e) & ~(|f);
`endif
    // Subnormals use the min-normal exponent with a zero hidden bit.
    o.exp  = (|e) ? e : EXP_W'(1);
    o.sig  = {|e, f};
    return o;
  endfunction

  // Handshake: a stage may load when it is empty or its content moves on this edge.
  logic w_s1_free, w_s2_free, w_s3_free;
  logic r_s1_valid, r_s2_valid, r_s3_valid;

  assign w_s3_free = ~r_s3_valid | out_ready;
  assign w_s2_free = ~r_s2_valid | w_s3_free;
  assign w_s1_free = ~r_s1_valid | w_s2_free;
  assign in_ready  = w_s1_free;

  // ---------------- S1: unpack and special-case select ----------------
  op_t          w_oa, w_ob;
  logic         w_sign, w_sp;
  logic [W-1:0] w_sp_p;
  logic [3:0]   w_sp_flags;
  logic [5:0]   w_sp_cls;

  assign w_oa   = unpack_op(a);
  assign w_ob   = unpack_op(b);
  assign w_sign = a[W-1] ^ b[W-1];

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_sp       = 1'b1;
    w_sp_p     = '0;
    w_sp_flags = '0;
    w_sp_cls   = CLS_ZERO;
    if (w_oa.snan) begin
      w_sp_p = a | QBIT;  w_sp_flags = FL_INV;  w_sp_cls = CLS_QNAN;
    end else if (w_ob.snan) begin
      w_sp_p = b | QBIT;  w_sp_flags = FL_INV;  w_sp_cls = CLS_QNAN;
    end else if (w_oa.nan) begin
      w_sp_p = a;  w_sp_cls = CLS_QNAN;
    end else if (w_ob.nan) begin
      w_sp_p = b;  w_sp_cls = CLS_QNAN;
    end else if ((w_oa.inf & w_ob.zero) | (w_oa.zero & w_ob.inf)) begin
      w_sp_p     = {w_sign, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_sp_flags = FL_INV;
      w_sp_cls   = CLS_QNAN;
    end else if (w_oa.inf | w_ob.inf) begin
      w_sp_p   = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_sp_cls = CLS_INF;
    end else if (w_oa.zero | w_ob.zero) begin
      w_sp_p   = {w_sign, {(W-1){1'b0}}};
      w_sp_cls = CLS_ZERO;
    end else begin
      w_sp = 1'b0;
    end
  end

  logic             r_s1_sp, r_s1_sign;
  logic [W-1:0]     r_s1_sp_p;
  logic [3:0]       r_s1_sp_flags;
  logic [5:0]       r_s1_sp_cls;
  logic [EXP_W-1:0] r_s1_ea, r_s1_eb;
  logic [SW-1:0]    r_s1_ma, r_s1_mb;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset too, so p/flags/cls read 0 straight out of reset.
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_sp       <= 1'b0;
      r_s1_sign     <= 1'b0;
      r_s1_sp_p     <= '0;
      r_s1_sp_flags <= '0;
      r_s1_sp_cls   <= '0;
      r_s1_ea       <= '0;
      r_s1_eb       <= '0;
      r_s1_ma       <= '0;
      r_s1_mb       <= '0;
    end else if (w_s1_free) begin
      // NOTE: non-blocking assignments so every stage samples its pre-edge inputs.
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sp       <= w_sp;
        r_s1_sign     <= w_sign;
        r_s1_sp_p     <= w_sp_p;
        r_s1_sp_flags <= w_sp_flags;
        r_s1_sp_cls   <= w_sp_cls;
        r_s1_ea       <= w_oa.exp;
        r_s1_eb       <= w_ob.exp;
        r_s1_ma       <= w_oa.sig;
        r_s1_mb       <= w_ob.sig;
      end
    end
  end

  // ---------------- S2: significand product and exponent sum ----------------
  logic [PW-1:0]           w_prod;
  logic signed [EXP_W+1:0] w_esum;

  assign w_prod = PW'(r_s1_ma) * PW'(r_s1_mb);
  assign w_esum = signed'({2'b00, r_s1_ea}) + signed'({2'b00, r_s1_eb}) - BIAS_X;

  logic                    r_s2_sp, r_s2_sign;
  logic [W-1:0]            r_s2_sp_p;
  logic [3:0]              r_s2_sp_flags;
  logic [5:0]              r_s2_sp_cls;
  logic [PW-1:0]           r_s2_prod;
  logic signed [EXP_W+1:0] r_s2_esum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid    <= 1'b0;
      r_s2_sp       <= 1'b0;
      r_s2_sign     <= 1'b0;
      r_s2_sp_p     <= '0;
      r_s2_sp_flags <= '0;
      r_s2_sp_cls   <= '0;
      r_s2_prod     <= '0;
      r_s2_esum     <= '0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sp       <= r_s1_sp;
        r_s2_sign     <= r_s1_sign;
        r_s2_sp_p     <= r_s1_sp_p;
        r_s2_sp_flags <= r_s1_sp_flags;
        r_s2_sp_cls   <= r_s1_sp_cls;
        r_s2_prod     <= w_prod;
        r_s2_esum     <= w_esum;
      end
    end
  end

  // ---------------- S3: normalise, denormalise, round ----------------
  logic [LZW-1:0]       w_lzc;
  logic                 w_found;
  logic [PW-1:0]        w_norm;
  logic signed [XW-1:0] w_exp, w_efld;
  int                   w_sh;
  logic                 w_tiny, w_shst, w_guard, w_stick, w_inc, w_inexact, w_ovf, w_flush;
  logic [SW-1:0]        w_mant;
  logic [SW:0]          w_sum;
  logic [MAN_W-1:0]     w_frac;
  logic [W-1:0]         w_res_p;
  logic [3:0]           w_res_flags;
  logic [5:0]           w_res_cls;

  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int i = PW - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (r_s2_prod[i]) w_found = 1'b1;
        else              w_lzc   = w_lzc + LZW'(1);
      end
    end
    // Leading one goes to the top bit; exponent is the biased value of that position.
    w_norm = r_s2_prod << w_lzc;
    w_exp  = XW'(r_s2_esum) + XW'(1) - signed'(XW'(w_lzc));
    w_tiny = (w_exp < XW'(1));
    w_sh   = 0;
    w_shst = 1'b0;
    if (w_tiny) begin
      w_sh = int'(XW'(1) - w_exp);
      for (int i = 0; i < PW; i++) begin
        if (i < w_sh) w_shst = w_shst | w_norm[i];
      end
      w_norm = (w_sh >= PW) ? '0 : (w_norm >> w_sh);
      w_exp  = '0;
    end
    w_mant    = w_norm[PW-1 -: SW];
    w_guard   = w_norm[MAN_W];
    w_stick   = w_shst | (|w_norm[MAN_W-1:0]);
    w_inc     = w_guard & (w_stick | w_mant[0]);
    w_sum     = {1'b0, w_mant} + (SW+1)'(w_inc);
    w_inexact = w_guard | w_stick;
    // A carry out, or a subnormal gaining its hidden bit, bumps the exponent field.
    w_efld    = w_exp + signed'(XW'(w_sum[SW] | (w_tiny & w_sum[MAN_W])));
    w_frac    = w_sum[SW] ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
    w_ovf     = (w_efld >= XW'(EMAXF));
`ifdef FP_MUL_FTZ_EN
    w_flush   = w_tiny & ~w_sum[MAN_W];
`else
    w_flush   = ~(|w_sum);
`endif
    if (w_ovf) begin
      w_res_p     = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_res_flags = FL_OV | FL_IX;
      w_res_cls   = CLS_INF;
    end else if (w_flush) begin
      w_res_p     = {r_s2_sign, {(W-1){1'b0}}};
      w_res_flags = FL_UF | FL_IX;
      w_res_cls   = CLS_ZERO;
    end else begin
      w_res_p     = {r_s2_sign, w_efld[EXP_W-1:0], w_frac};
      w_res_flags = ((w_tiny & w_inexact) ? FL_UF : 4'b0) | (w_inexact ? FL_IX : 4'b0);
      w_res_cls   = (w_tiny & ~w_sum[MAN_W]) ? CLS_SUB : CLS_NORM;
    end
  end

  logic [W-1:0] r_p;
  logic [3:0]   r_flags;
  logic [5:0]   r_cls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s3_valid <= 1'b0;
      r_p        <= '0;
      r_flags    <= '0;
      r_cls      <= '0;
    end else if (w_s3_free) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_p     <= r_s2_sp ? r_s2_sp_p     : w_res_p;
        r_flags <= r_s2_sp ? r_s2_sp_flags : w_res_flags;
        r_cls   <= r_s2_sp ? r_s2_sp_cls   : w_res_cls;
      end
    end
  end

  assign out_valid = r_s3_valid;
  assign p         = r_p;
  assign flags     = r_flags;
  assign cls       = r_cls;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe (bfloat16 defaults): arithmetic, specials,
// range limits, backpressure ordering/stability and mid-flight reset.
module tb_fp_mul_pipe;
  localparam logic [5:0] C_QN  = 6'b010000;
  localparam logic [5:0] C_SUB = 6'b001000;
  localparam logic [5:0] C_NRM = 6'b000100;
  localparam logic [5:0] C_INF = 6'b000010;
  localparam logic [5:0] C_ZR  = 6'b000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] p;
  logic [3:0]  flags;
  logic [5:0]  cls;

  int errors = 0;
  int checks = 0;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .flags(flags), .cls(cls)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One op with out_ready=1: checks acceptance, 3-cycle latency and the result.
  task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] ep, input logic [3:0] ef, input logic [5:0] ec);
    int lat;
    @(negedge clk);
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_p"}, p, ep);
    check({tag, "_flags"}, flags, ef);
    check({tag, "_cls"}, cls, ec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    logic [15:0] bv [6];
    logic [23:0] pat;
    logic [15:0] held;
    logic        stalled, saw_full;
    int          tx, rx, cyc;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 0);
    check("rst_flags", flags, 0);
    check("rst_cls", cls, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("post_rst_in_ready", in_ready, 1);

    // Arithmetic and rounding
    run_one("one_x_two", 16'h3F80, 16'h4000, 16'h4000, 4'h0, C_NRM);
    run_one("round_dn",  16'h3F81, 16'h3F81, 16'h3F82, 4'h1, C_NRM);
    run_one("exact_sq",  16'h3FC0, 16'h3FC0, 16'h4010, 4'h0, C_NRM);
    run_one("tie_up",    16'h3F81, 16'h3FC0, 16'h3FC2, 4'h1, C_NRM);
    run_one("tie_even",  16'h3F83, 16'h3FC0, 16'h3FC4, 4'h1, C_NRM);

    // Special operands
    run_one("inf_x_zero", 16'h7F80, 16'h0000, 16'h7FC0, 4'h2, C_QN);
    run_one("snan_a",     16'h7F81, 16'h3F80, 16'h7FC1, 4'h2, C_QN);
    run_one("snan_b_pri", 16'h7FC0, 16'h7F81, 16'h7FC1, 4'h2, C_QN);
    run_one("qnan_pass",  16'h3F80, 16'hFFC5, 16'hFFC5, 4'h0, C_QN);
    run_one("neg_inf",    16'hFF80, 16'h4000, 16'hFF80, 4'h0, C_INF);
    run_one("neg_zero",   16'h8000, 16'h4000, 16'h8000, 4'h0, C_ZR);

    // Range limits
    run_one("overflow",   16'h7F7F, 16'h4000, 16'h7F80, 4'h9, C_INF);
`ifdef FP_MUL_FTZ_EN
    run_one("sub_exact",  16'h0080, 16'h3F00, 16'h0000, 4'h5, C_ZR);
    run_one("sub_to_0",   16'h0001, 16'h3E80, 16'h0000, 4'h0, C_ZR);
`else
    run_one("sub_exact",  16'h0080, 16'h3F00, 16'h0040, 4'h0, C_SUB);
    run_one("sub_to_0",   16'h0001, 16'h3E80, 16'h0000, 4'h5, C_ZR);
`endif

    // Backpressure stream: 1.0 * x = x, consumer follows a stall pattern
    bv  = '{16'h4000, 16'h4010, 16'h4020, 16'h4030, 16'h4040, 16'h4050};
    pat = {13'h1FFF, 11'b100_0110_1001};
    tx = 0; rx = 0; cyc = 0; stalled = 1'b0; saw_full = 1'b0; held = '0;
    while (rx < 6 && cyc < 60) begin
      @(negedge clk);
      out_ready = (cyc < 24) ? pat[cyc] : 1'b1;
      in_valid  = (tx < 6);
      if (tx < 6) begin
        a = 16'h3F80;
        b = bv[tx];
      end
      #1;
      if (stalled) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_p", p, held);
      end
      if (in_valid && !in_ready) saw_full = 1'b1;
      if (in_valid && in_ready) tx++;
      if (out_valid && out_ready) begin
        check($sformatf("bp_p%0d", rx), p, bv[rx]);
        rx++;
      end
      stalled = out_valid && !out_ready;
      held    = p;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_rx_count", rx, 6);
    check("bp_tx_count", tx, 6);
    check("bp_full_seen", saw_full, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("bp_no_dup", out_valid, 0);
    end

    // Reset with three ops in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 16'h3F80; b = 16'h4000;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("mf_full_valid", out_valid, 1);
    check("mf_full_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check("mf_async_valid", out_valid, 0);
    check("mf_async_p", p, 0);
    check("mf_async_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("mf_empty_valid", out_valid, 0);
      check("mf_empty_in_ready", in_ready, 1);
    end
    run_one("after_rst", 16'h3F80, 16'h4000, 16'h4000, 4'h0, C_NRM);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-style floating-point multiplier. It is the next-generation successor of the combinational bfloat16 multiply unit; defaults give bfloat16.
- Adds a valid/ready handshake with full backpressure, round-to-nearest-even, correct subnormal handling and NaN quieting.
- Sits between operand-fetch and result-writeback in the datapath.

Parameters:
- EXP_W, 8, exponent field width (>=3).
- MAN_W, 7, stored fraction width (>=2); word width W = 1+EXP_W+MAN_W.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair a/b valid
- in_ready  output  1  pipeline accepts a/b this cycle
- a  input  W  operand A
- b  input  W  operand B
- out_valid  output  1  result p/flags/cls valid
- out_ready  input  1  consumer accepts result
- p  output  W  product
- flags  output  4  {overflow, underflow, invalid, inexact}
- cls  output  6  one-hot result class {snan, qnan, subnormal, normal, inf, zero}

Behaviour:
- Reset (async, active-high): all stage valids=0, out_valid=0, p=0, flags=0, cls=0. in_ready=1 from the first edge after rst deasserts. Reset mid-operation discards all in-flight ops.
- Transfer in: in_valid&in_ready. Transfer out: out_valid&out_ready.
- Latency: exactly 3 cycles, accept edge to out_valid, with no stall.
- Throughput: 1 op/cycle when out_ready=1.
- Stall rule: stage k advances iff stage k+1 is empty or advancing. in_ready = !s1_valid | s1_advance (combinational from out_ready, no extra bubble).
- Under stall, p/flags/cls/out_valid hold stable until accepted. No op is dropped or duplicated.
- S1 (unpack): classify a and b.
  - Exponent field 0 with fraction !=0 is subnormal: effective exponent 1-bias, hidden bit 0.
  - bias = 2^(EXP_W-1)-1.
  - Special-case select, priority order:
    - sNaN in A, else B: output = that input with fraction MSB set; flags invalid; cls qnan.
    - qNaN in A, else B: passthrough; cls qnan.
    - inf × zero: {sign, all-ones exp, 1, 0…}; invalid; cls qnan.
    - inf × other: signed inf; cls inf; no flags.
    - zero × any: signed zero; cls zero.
  - sign = a[W-1]^b[W-1] for every non-NaN result.
- S2 (multiply): significand product is (MAN_W+1)×(MAN_W+1) unsigned → 2(MAN_W+1) bits. Exponent sum held signed, width EXP_W+2.
- S3 (normalise/round):
  - Normalise left by the leading-zero count for subnormal inputs, right by 1 if the product MSB is set.
  - If exp < emin, right-shift into subnormal range, collecting sticky.
  - Round to nearest, ties to even, using guard/round/sticky.
  - A rounding carry renormalises; a subnormal that rounds up to min-normal yields cls normal.
  - Outcomes:
    - exp > emax after rounding → signed inf; overflow=1, inexact=1.
    - Result rounds to 0 → signed zero; underflow=1, inexact=1.
    - Tiny and inexact → subnormal; underflow=1.
    - Any discarded nonzero bit → inexact=1.
- cls is exactly one-hot for every valid output. snan never appears, because outputs are always quieted; the bit is reserved.

Optional Feature:
- FP_MUL_FTZ_EN defined: subnormal inputs are treated as signed zero, and subnormal results are flushed to signed zero with underflow=1 and inexact=1. cls subnormal never asserts.
- Undefined: full gradual-underflow behaviour as above.
- Latency is 3 either way.

Test Plan:
- Normal: a=0x3F80 (1.0), b=0x4000 (2.0), out_ready=1 → 3 cycles later p=0x4000, cls=normal, flags=0.
- Rounding: a=b=0x3F81 → p=0x3F82, inexact=1, cls normal. Then a=0x3FC0, b=0x3FC0 (1.5²) → p=0x4010 exact, flags=0.
- Specials: 0x7F80×0x0000 → p=0x7FC0, invalid=1, cls qnan. 0x7F81×0x3F80 → p=0x7FC1, invalid=1. 0xFF80×0x4000 → p=0xFF80, cls inf, flags=0.
- Range: 0x7F7F×0x4000 → p=0x7F80, overflow=1, inexact=1. 0x0080×0x3F00 → p=0x0040, cls subnormal, underflow=0 (exact). 0x0001×0x3E80 → p=0x0000, underflow=1, inexact=1 (FTZ off).
- Backpressure: stream 6 ops with out_ready pattern 1,0,0,1,0,1,1… → in_ready drops when the pipe is full, results arrive in order with no loss or duplication, and p is stable while out_valid&!out_ready.
- Reset mid-flight: assert rst with 3 ops in flight → out_valid=0 immediately (async), and after release the pipe is empty with in_ready=1.
